// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
package rf_pkg;

    localparam int unsigned RF_XLEN  = 32;
    localparam int unsigned RF_NREGS = 32;
    localparam int unsigned RF_NRD   = 2;
    localparam int unsigned RF_NWR   = 2;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned rf_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Bit offset of port `port` in a packed bus of `width`-bit fields.
    function automatic int unsigned rf_slice(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_wr_arbiter.sv
// Resolves all write ports against one query address: hit flag, winning
// (highest-index) data and the number of ports that matched.
module rf_wr_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = RF_XLEN,
    parameter int unsigned AW       = 5,
    parameter int unsigned NWR      = RF_NWR,
    parameter int unsigned CW       = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic [NWR-1:0]      i_wr_en,
    input  logic [NWR*AW-1:0]   i_wr_addr,
    input  logic [NWR*XLEN-1:0] i_wr_data,
    input  logic [AW-1:0]       i_query_addr,
    output logic                o_hit,
    output logic [XLEN-1:0]     o_data,
    output logic [CW-1:0]       o_count
);

    logic writable;

    assign writable = !(ZERO_REG && (i_query_addr == '0));

    // Ascending scan so the highest-index matching port overrides earlier ones.
    always_comb begin
        o_hit   = 1'b0;
        o_data  = '0;
        o_count = '0;
        for (int p = 0; p < NWR; p++) begin
            if (writable && i_wr_en[p] &&
                (i_wr_addr[rf_slice(p, AW) +: AW] == i_query_addr)) begin
                o_hit   = 1'b1;
                o_data  = i_wr_data[rf_slice(p, XLEN) +: XLEN];
                o_count = o_count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with write-to-read bypass and a
// per-register busy scoreboard for decode-stage RAW hazard detection.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = RF_XLEN,
    parameter int unsigned NREGS    = RF_NREGS,
    parameter int unsigned NRD      = RF_NRD,
    parameter int unsigned NWR      = RF_NWR,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = rf_clog2(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clk_enable,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_data,
    output logic [NRD-1:0]      o_rd_busy,
    input  logic [NWR-1:0]      i_wr_en,
    input  logic [NWR*AW-1:0]   i_wr_addr,
    input  logic [NWR*XLEN-1:0] i_wr_data,
    input  logic                i_alloc_en,
    input  logic [AW-1:0]       i_alloc_addr,
    output logic [NREGS-1:0]    o_busy_vec,
    output logic                o_wr_conflict,
    input  logic [AW-1:0]       i_dbg_addr,
    output logic [XLEN-1:0]     o_dbg_data
);

    localparam int unsigned CW = rf_clog2(NWR + 1);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic             conflict_q, conflict_d;

    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_val [NREGS];
    logic [CW-1:0]    wr_cnt [NREGS];

    logic [NRD-1:0]   rd_hit;
    logic [XLEN-1:0]  rd_val [NRD];
    logic [CW-1:0]    rd_cnt [NRD];

    // Write decode: one arbiter per register.
    for (genvar r = 0; r < NREGS; r++) begin : g_wr_dec
        rf_wr_arbiter #(
            .XLEN     (XLEN),
            .AW       (AW),
            .NWR      (NWR),
            .CW       (CW),
            .ZERO_REG (ZERO_REG)
        ) u_wr_arb (
            .i_wr_en      (i_wr_en),
            .i_wr_addr    (i_wr_addr),
            .i_wr_data    (i_wr_data),
            .i_query_addr (AW'(r)),
            .o_hit        (wr_hit[r]),
            .o_data       (wr_val[r]),
            .o_count      (wr_cnt[r])
        );
    end

    // Read ports: arbiter supplies the bypass candidate for each port.
    for (genvar k = 0; k < NRD; k++) begin : g_rd_port
        logic [AW-1:0] addr;
        logic          bypass_hit;

        assign addr       = i_rd_addr[k*AW +: AW];
        assign bypass_hit = BYPASS && rd_hit[k];

        rf_wr_arbiter #(
            .XLEN     (XLEN),
            .AW       (AW),
            .NWR      (NWR),
            .CW       (CW),
            .ZERO_REG (ZERO_REG)
        ) u_rd_arb (
            .i_wr_en      (i_wr_en),
            .i_wr_addr    (i_wr_addr),
            .i_wr_data    (i_wr_data),
            .i_query_addr (addr),
            .o_hit        (rd_hit[k]),
            .o_data       (rd_val[k]),
            .o_count      (rd_cnt[k])
        );

        assign o_rd_data[k*XLEN +: XLEN] =
            bypass_hit                       ? rd_val[k] :
            (ZERO_REG && (addr == '0))       ? '0        :
                                               regs_q[addr];
        assign o_rd_busy[k] = busy_q[addr] && !bypass_hit;
    end

    // Read-port collision counts carry no meaning; fold them away.
    logic unused_rd_cnt;
    always_comb begin
        unused_rd_cnt = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            unused_rd_cnt = unused_rd_cnt ^ (^rd_cnt[k]);
        end
    end

    // Allocation beats a same-cycle writeback: a newer producer is in flight.
    always_comb begin
        busy_d     = busy_q;
        conflict_d = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if (ZERO_REG && (r == 0)) begin
                busy_d[r] = 1'b0;
            end else if (i_alloc_en && (i_alloc_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_d[r] = 1'b0;
            end
            if (wr_cnt[r] > CW'(1)) begin
                conflict_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else if (i_clk_enable) begin
            for (int r = 0; r < NREGS; r++) begin
                if (wr_hit[r]) begin
                    regs_q[r] <= wr_val[r];
                end
            end
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign o_busy_vec    = busy_q;
    assign o_wr_conflict = conflict_q;
    assign o_dbg_data    = regs_q[i_dbg_addr];

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp with default parameters.
module tb_reg_file_mp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;
    localparam int unsigned AW    = 5;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_clk_enable;
    logic [NRD*AW-1:0]   i_rd_addr;
    logic [NRD*XLEN-1:0] o_rd_data;
    logic [NRD-1:0]      o_rd_busy;
    logic [NWR-1:0]      i_wr_en;
    logic [NWR*AW-1:0]   i_wr_addr;
    logic [NWR*XLEN-1:0] i_wr_data;
    logic                i_alloc_en;
    logic [AW-1:0]       i_alloc_addr;
    logic [NREGS-1:0]    o_busy_vec;
    logic                o_wr_conflict;
    logic [AW-1:0]       i_dbg_addr;
    logic [XLEN-1:0]     o_dbg_data;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 i_clk = ~i_clk;

    reg_file_mp u_dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_clk_enable  (i_clk_enable),
        .i_rd_addr     (i_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_rd_busy     (o_rd_busy),
        .i_wr_en       (i_wr_en),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .i_alloc_en    (i_alloc_en),
        .i_alloc_addr  (i_alloc_addr),
        .o_busy_vec    (o_busy_vec),
        .o_wr_conflict (o_wr_conflict),
        .i_dbg_addr    (i_dbg_addr),
        .o_dbg_data    (o_dbg_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_wr_en      = '0;
        i_wr_addr    = '0;
        i_wr_data    = '0;
        i_alloc_en   = 1'b0;
        i_alloc_addr = '0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        i_wr_en[p]             = 1'b1;
        i_wr_addr[p*AW +: AW]  = a;
        i_wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        i_rd_addr[k*AW +: AW] = a;
    endtask

    function automatic logic [XLEN-1:0] rd_data(input int k);
        return o_rd_data[k*XLEN +: XLEN];
    endfunction

    initial begin
        i_rst        = 1'b1;
        i_clk_enable = 1'b1;
        i_rd_addr    = '0;
        i_dbg_addr   = '0;
        clear_inputs();
        step();
        step();
        i_rst = 1'b0;

        // Reset state
        i_dbg_addr = 5'd5;
        #1;
        check("rst_busy_vec", 64'(o_busy_vec), 64'h0);
        check("rst_conflict", 64'(o_wr_conflict), 64'h0);
        check("rst_dbg_x5", 64'(o_dbg_data), 64'h0);

        // Single write to x5
        set_wr(0, 5'd5, 32'hDEADBEEF);
        step();
        clear_inputs();
        set_rd(0, 5'd5);
        set_rd(1, 5'd6);
        #1;
        check("wr_x5_rd0", 64'(rd_data(0)), 64'hDEADBEEF);
        check("wr_x5_dbg", 64'(o_dbg_data), 64'hDEADBEEF);
        check("wr_x6_rd1", 64'(rd_data(1)), 64'h0);
        check("wr_busy_vec", 64'(o_busy_vec), 64'h0);

        // Two-port collision on x3 with bypass
        set_wr(0, 5'd3, 32'h11);
        set_wr(1, 5'd3, 32'h22);
        set_rd(0, 5'd3);
        #1;
        check("coll_bypass", 64'(rd_data(0)), 64'h22);
        check("coll_conf_pre", 64'(o_wr_conflict), 64'h0);
        step();
        clear_inputs();
        i_dbg_addr = 5'd3;
        #1;
        check("coll_conf_set", 64'(o_wr_conflict), 64'h1);
        check("coll_x3", 64'(o_dbg_data), 64'h22);
        step();
        check("coll_conf_pulse", 64'(o_wr_conflict), 64'h0);

        // Allocate x7, then writeback while reading
        i_alloc_en   = 1'b1;
        i_alloc_addr = 5'd7;
        step();
        clear_inputs();
        set_rd(0, 5'd7);
        #1;
        check("alloc_busy7", 64'(o_busy_vec[7]), 64'h1);
        check("alloc_rd_busy", 64'(o_rd_busy[0]), 64'h1);
        set_wr(1, 5'd7, 32'h55);
        #1;
        check("wb_rd_busy", 64'(o_rd_busy[0]), 64'h0);
        check("wb_rd_data", 64'(rd_data(0)), 64'h55);
        step();
        clear_inputs();
        #1;
        check("wb_busy7_clr", 64'(o_busy_vec[7]), 64'h0);
        check("wb_x7", 64'(rd_data(0)), 64'h55);

        // Alloc and write x9 same cycle: alloc wins
        i_alloc_en   = 1'b1;
        i_alloc_addr = 5'd9;
        set_wr(0, 5'd9, 32'h1);
        step();
        clear_inputs();
        i_dbg_addr = 5'd9;
        #1;
        check("allocwr_busy9", 64'(o_busy_vec[9]), 64'h1);
        check("allocwr_x9", 64'(o_dbg_data), 64'h1);

        // Zero register: writes, alloc and collisions all ignored
        set_wr(0, 5'd0, 32'hFFFFFFFF);
        set_wr(1, 5'd0, 32'hFFFFFFFF);
        i_alloc_en   = 1'b1;
        i_alloc_addr = 5'd0;
        set_rd(1, 5'd0);
        #1;
        check("x0_no_bypass", 64'(rd_data(1)), 64'h0);
        step();
        clear_inputs();
        i_dbg_addr = 5'd0;
        #1;
        check("x0_dbg", 64'(o_dbg_data), 64'h0);
        check("x0_rd", 64'(rd_data(1)), 64'h0);
        check("x0_busy", 64'(o_busy_vec[0]), 64'h0);
        check("x0_conflict", 64'(o_wr_conflict), 64'h0);

        // Collision on x10, then stall: conflict holds, x4 untouched
        set_wr(0, 5'd10, 32'h1);
        set_wr(1, 5'd10, 32'h2);
        step();
        clear_inputs();
        #1;
        check("x10_conflict", 64'(o_wr_conflict), 64'h1);
        i_clk_enable = 1'b0;
        set_wr(0, 5'd4, 32'hA5);
        i_alloc_en   = 1'b1;
        i_alloc_addr = 5'd4;
        set_rd(0, 5'd4);
        #1;
        check("stall_bypass", 64'(rd_data(0)), 64'hA5);
        step();
        clear_inputs();
        i_dbg_addr = 5'd4;
        #1;
        check("stall_x4", 64'(o_dbg_data), 64'h0);
        check("stall_busy4", 64'(o_busy_vec[4]), 64'h0);
        check("stall_conf_hold", 64'(o_wr_conflict), 64'h1);
        check("stall_busy9_hold", 64'(o_busy_vec[9]), 64'h1);

        // Reset while stalled clears everything
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_clk_enable = 1'b1;
        i_dbg_addr = 5'd5;
        #1;
        check("rst2_busy_vec", 64'(o_busy_vec), 64'h0);
        check("rst2_conflict", 64'(o_wr_conflict), 64'h0);
        check("rst2_x5", 64'(o_dbg_data), 64'h0);
        set_rd(0, 5'd3);
        #1;
        check("rst2_x3", 64'(rd_data(0)), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
